// File: rtl/neuron_pkg.sv
// Shared fixed-point constants and the spike event record used by the neuron blocks.
package neuron_pkg;

  localparam int FRAC_BITS = 12;
  localparam logic signed [15:0] ONE  = 16'sd4096;
  localparam logic signed [15:0] HALF = 16'sd2048;

  // Event record at default widths; packed order is {ts, isi, peak}.
  typedef struct packed {
    logic [31:0]        ts;
    logic [31:0]        isi;
    logic signed [15:0] peak;
  } evt_t;

  function automatic int evt_width(input int ts_w, input int data_w);
    return 2 * ts_w + data_w;
  endfunction

endpackage

// File: rtl/event_fifo.sv
// First-word-fall-through FIFO whose head is held in a register, so dout/valid
// come straight from flops. Handshake: a word leaves on a rising edge where
// valid and ready are both high; push succeeds unless full with no pop on the same edge.
module event_fifo #(
  parameter int WIDTH = 80,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  output logic             empty,
  output logic             valid,
  input  logic             ready,
  output logic [WIDTH-1:0] dout
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr, rd_ptr_n;
  logic [AW:0]      count, count_n, count_after_pop;
  logic             pop, push_ok;
  logic [WIDTH-1:0] head_n;

  assign full    = (count == DEPTH_C);
  assign empty   = (count == '0);
  assign pop     = valid & ready;
  assign push_ok = push & (~full | pop);

  assign rd_ptr_n        = rd_ptr + AW'(pop);
  assign count_after_pop = count - (AW + 1)'(pop);
  assign count_n         = count_after_pop + (AW + 1)'(push_ok);

  // Next head: the incoming word if nothing else remains, otherwise the stored one.
  always_comb begin
    head_n = mem[rd_ptr_n];
    if (count_after_pop == '0) head_n = din;
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      valid  <= 1'b0;
      dout   <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      rd_ptr <= rd_ptr_n;
      count  <= count_n;
      valid  <= (count_n != '0);
      if (count_n != '0) dout <= head_n;
    end
  end

endmodule

// File: rtl/spike_detector.sv
// Hysteresis spike detector: timestamps rising crossings, tracks the peak and
// queues {ts, isi, peak} events for a valid/ready consumer.
module spike_detector
  import neuron_pkg::*;
#(
  parameter int DATA_W     = 16,
  parameter int TS_W       = 32,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic signed [DATA_W-1:0] v_in,
  input  logic                     v_valid,
  input  logic signed [DATA_W-1:0] th_hi,
  input  logic signed [DATA_W-1:0] th_lo,
  output logic                     evt_valid,
  input  logic                     evt_ready,
  output logic [TS_W-1:0]          evt_ts,
  output logic [TS_W-1:0]          evt_isi,
  output logic signed [DATA_W-1:0] evt_peak,
  output logic [15:0]              spike_count,
  output logic                     overflow,
  output logic                     dbg_state
);

  localparam int EW = evt_width(TS_W, DATA_W);
  localparam logic [0:0] BELOW = 1'b0;
  localparam logic [0:0] ABOVE = 1'b1;

  logic [0:0]               state;
  logic [TS_W-1:0]          ts, rise_ts, prev_rise, isi;
  logic signed [DATA_W-1:0] peak;
  logic                     first;
  logic                     push, drop, fifo_full, fifo_empty;
  logic [EW-1:0]            fifo_din, fifo_dout;

  assign dbg_state = state;

  // The falling sample completes the spike and is never folded into peak.
  assign push     = v_valid && (state == ABOVE) && (v_in < th_lo);
  assign isi      = first ? '0 : rise_ts - prev_rise;
  assign fifo_din = {rise_ts, isi, peak};
  assign drop     = push & fifo_full & ~(~fifo_empty & evt_ready);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= BELOW;
      ts          <= '0;
      rise_ts     <= '0;
      prev_rise   <= '0;
      peak        <= '0;
      first       <= 1'b1;
      spike_count <= '0;
      overflow    <= 1'b0;
    end else begin
      if (drop) overflow <= 1'b1;
      if (v_valid) begin
        ts <= ts + TS_W'(1);
        case (state)
          BELOW: begin
            if (v_in >= th_hi) begin
              state   <= ABOVE;
              rise_ts <= ts;
              peak    <= v_in;
            end
          end
          ABOVE: begin
            if (v_in < th_lo) begin
              // Dropped spikes still advance the ISI reference and the count.
              state     <= BELOW;
              prev_rise <= rise_ts;
              first     <= 1'b0;
              if (spike_count != 16'hFFFF) spike_count <= spike_count + 16'd1;
            end else if (v_in > peak) begin
              peak <= v_in;
            end
          end
          default: state <= BELOW;
        endcase
      end
    end
  end

  event_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (fifo_din),
    .full  (fifo_full),
    .empty (fifo_empty),
    .valid (evt_valid),
    .ready (evt_ready),
    .dout  (fifo_dout)
  );

  assign {evt_ts, evt_isi, evt_peak} = fifo_dout;

endmodule

// File: tb/tb_spike_detector.sv
// Bench for spike_detector: directed scenarios plus randomized samples, checked
// against a spike-list reference model and an expected-event queue.
module tb_spike_detector;

  localparam int DATA_W = 16;
  localparam int TS_W   = 32;
  localparam int DEPTH  = 8;
  localparam int EW     = 2 * TS_W + DATA_W;

  logic                     clk = 1'b0;
  logic                     rst = 1'b0;
  logic signed [DATA_W-1:0] v_in = '0;
  logic                     v_valid = 1'b0;
  logic signed [DATA_W-1:0] th_hi = '0;
  logic signed [DATA_W-1:0] th_lo = '0;
  logic                     evt_valid;
  logic                     evt_ready = 1'b0;
  logic [TS_W-1:0]          evt_ts, evt_isi;
  logic signed [DATA_W-1:0] evt_peak;
  logic [15:0]              spike_count;
  logic                     overflow;
  logic                     dbg_state;

  spike_detector #(
    .DATA_W     (DATA_W),
    .TS_W       (TS_W),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .v_in        (v_in),
    .v_valid     (v_valid),
    .th_hi       (th_hi),
    .th_lo       (th_lo),
    .evt_valid   (evt_valid),
    .evt_ready   (evt_ready),
    .evt_ts      (evt_ts),
    .evt_isi     (evt_isi),
    .evt_peak    (evt_peak),
    .spike_count (spike_count),
    .overflow    (overflow),
    .dbg_state   (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [EW-1:0] got, input logic [EW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // reference model: list of samples in the current spike, list of rise times
  logic [EW-1:0]            exp_q[$];
  logic signed [DATA_W-1:0] spike_samples[$];
  logic [TS_W-1:0]          rise_times[$];
  logic [TS_W-1:0]          m_ts;
  logic [TS_W-1:0]          m_rise;
  bit                       m_in_spike;
  bit                       m_ovf;
  logic [15:0]              m_cnt;

  task automatic model_reset();
    exp_q.delete();
    spike_samples.delete();
    rise_times.delete();
    m_ts       = '0;
    m_rise     = '0;
    m_in_spike = 1'b0;
    m_ovf      = 1'b0;
    m_cnt      = '0;
  endtask

  function automatic logic signed [DATA_W-1:0] spike_max();
    logic signed [DATA_W-1:0] mx;
    mx = spike_samples[0];
    foreach (spike_samples[i]) if (spike_samples[i] > mx) mx = spike_samples[i];
    return mx;
  endfunction

  // One cycle: check outputs at the falling edge, then drive and predict the next edge.
  task automatic step(input int v, input bit vv, input bit rdy);
    logic [EW-1:0]   ev;
    logic [TS_W-1:0] isi;
    bit              pop, push;
    @(negedge clk);
    check("evt_valid", EW'(evt_valid), EW'(exp_q.size() != 0));
    if (exp_q.size() != 0) check("evt_head", {evt_ts, evt_isi, evt_peak}, exp_q[0]);
    check("spike_count", EW'(spike_count), EW'(m_cnt));
    check("overflow", EW'(overflow), EW'(m_ovf));
    check("state", EW'(dbg_state), EW'(m_in_spike));
    v_in      = DATA_W'(v);
    v_valid   = vv;
    evt_ready = rdy;
    pop  = rdy && (exp_q.size() != 0);
    push = 1'b0;
    ev   = '0;
    if (vv) begin
      if (!m_in_spike) begin
        if (v_in >= th_hi) begin
          m_in_spike = 1'b1;
          m_rise     = m_ts;
          spike_samples.delete();
          spike_samples.push_back(v_in);
        end
      end else if (v_in < th_lo) begin
        isi = (rise_times.size() == 0) ? '0 : m_rise - rise_times[$];
        ev  = {m_rise, isi, spike_max()};
        rise_times.push_back(m_rise);
        push       = 1'b1;
        m_in_spike = 1'b0;
        if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
      end else begin
        spike_samples.push_back(v_in);
      end
      m_ts = m_ts + TS_W'(1);
    end
    if (pop) void'(exp_q.pop_front());
    if (push) begin
      if (exp_q.size() >= DEPTH) m_ovf = 1'b1;
      else exp_q.push_back(ev);
    end
  endtask

  task automatic spike(input int hi, input int lo, input bit rdy);
    step(hi, 1'b1, rdy);
    step(lo, 1'b1, rdy);
  endtask

  task automatic reset_mid();
    @(posedge clk);
    #2;
    rst     = 1'b0;
    v_valid = 1'b0;
    #1;
    check("rst_evt_valid", EW'(evt_valid), '0);
    check("rst_evt_fields", {evt_ts, evt_isi, evt_peak}, '0);
    check("rst_spike_count", EW'(spike_count), '0);
    check("rst_overflow", EW'(overflow), '0);
    check("rst_state", EW'(dbg_state), '0);
    model_reset();
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    int tmp;
    model_reset();
    reset_mid();

    // first spike: rise at ts 1, peak 5000
    th_hi = 16'sd2048;
    th_lo = 16'sd0;
    step(0, 1, 1); step(3000, 1, 1); step(5000, 1, 1); step(4000, 1, 1); step(-100, 1, 0);
    step(0, 0, 0);
    #1;
    check("first_event", {evt_ts, evt_isi, evt_peak}, {32'd1, 32'd0, 16'd5000});
    check("first_count", EW'(spike_count), EW'(16'd1));

    // second spike rising at ts 120
    while (m_ts < 120) step(0, 1, 1);
    step(3000, 1, 1);
    step(-100, 1, 0);
    step(0, 0, 0);
    #1;
    check("second_event", {evt_ts, evt_isi, evt_peak}, {32'd120, 32'd119, 16'd3000});

    // sample gaps inside a spike: gap values must be ignored
    step(3000, 1, 1);
    for (int i = 0; i < 50; i++) step(int'($urandom_range(0, 20000)) - 10000, 0, 1);
    #1;
    check("gap_state", EW'(dbg_state), EW'(1'b1));
    step(3500, 1, 1);
    step(-100, 1, 0);
    step(0, 0, 0);
    #1;
    check("gap_event", {evt_ts, evt_isi, evt_peak}, {32'd122, 32'd2, 16'd3500});
    repeat (3) step(0, 0, 1);

    // nine spikes into an eight-deep buffer with no consumer
    reset_mid();
    for (int i = 0; i < 9; i++) spike(3000 + i, -100, 0);
    step(0, 0, 0);
    #1;
    check("ovf_flag", EW'(overflow), EW'(1'b1));
    check("ovf_count", EW'(spike_count), EW'(16'd9));
    check("ovf_head", {evt_ts, evt_isi, evt_peak}, {32'd0, 32'd0, 16'd3000});
    repeat (10) step(0, 0, 1);

    // push into a full buffer on the same edge as a pop
    reset_mid();
    for (int i = 0; i < 8; i++) spike(3000, -100, 0);
    step(3000, 1, 0);
    step(-100, 1, 1);
    step(0, 0, 0);
    #1;
    check("full_pop_ovf", EW'(overflow), EW'(1'b0));
    check("full_pop_count", EW'(spike_count), EW'(16'd9));
    repeat (10) step(0, 0, 1);

    // reset while above threshold
    reset_mid();
    spike(3000, -100, 1);
    step(4000, 1, 1);
    reset_mid();
    step(-100, 1, 1);
    step(3000, 1, 1);
    step(-100, 1, 0);
    step(0, 0, 0);
    #1;
    check("post_rst_event", {evt_ts, evt_isi, evt_peak}, {32'd1, 32'd0, 16'd3000});
    repeat (3) step(0, 0, 1);

    // randomized stimulus
    for (int blk = 0; blk < 12; blk++) begin
      if (blk % 5 == 4) reset_mid();
      tmp   = int'($urandom_range(0, 8000)) - 2000;
      th_hi = DATA_W'(tmp);
      th_lo = DATA_W'(tmp - int'($urandom_range(0, 4000)));
      for (int i = 0; i < 200; i++) begin
        step(int'($urandom_range(0, 20000)) - 10000,
             $urandom_range(0, 3) != 0,
             (blk % 3 == 1) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 3) != 0));
      end
    end
    repeat (12) step(0, 0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/spike_detector.md
SPIKE_DETECTOR -- requirements
Module: spike_detector

Interface
REQ-001 SHALL have parameter DATA_W, default 16, width of the signed Q3.12 membrane sample.
REQ-002 SHALL have parameter TS_W, default 32, width of the sample-index timestamp.
REQ-003 SHALL have parameter FIFO_DEPTH, default 8, event buffer entries (power of two, >=2).
REQ-004 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous and active-low.
REQ-006 SHALL have port v_in  input  DATA_W  signed membrane sample (core v output, Q3.12).
REQ-007 SHALL have port v_valid  input  1  v_in holds a new sample this cycle.
REQ-008 SHALL have port th_hi  input  DATA_W  signed rising threshold, Q3.12.
REQ-009 SHALL have port th_lo  input  DATA_W  signed falling (re-arm) threshold, Q3.12.
REQ-010 SHALL have port evt_valid  output  1  FIFO head holds an event.
REQ-011 SHALL have port evt_ready  input  1  consumer accepts the head event.
REQ-012 SHALL have port evt_ts  output  TS_W  sample index of the rising crossing.
REQ-013 SHALL have port evt_isi  output  TS_W  interval from previous rising crossing, in samples.
REQ-014 SHALL have port evt_peak  output  DATA_W  signed maximum v_in during the spike.
REQ-015 SHALL have port spike_count  output  16  saturating count of detected spikes.
REQ-016 SHALL have port overflow  output  1  sticky flag set when an event was dropped.

Function
REQ-017 SHALL keep sample counter ts, incremented by 1 on each v_valid cycle, wrapping modulo 2^TS_W; the sample in a cycle carries the pre-increment ts.
REQ-018 SHALL implement FSM states BELOW and ABOVE; cycles without v_valid change no state except the FIFO.
REQ-019 BELOW->ABOVE SHALL occur on v_valid with signed v_in >= th_hi; it captures rise_ts=ts and peak=v_in.
REQ-020 In ABOVE, peak SHALL update to v_in on v_valid when signed v_in > peak.
REQ-021 ABOVE->BELOW SHALL occur on v_valid with signed v_in < th_lo; only th_lo is tested in ABOVE and only th_hi in BELOW.
REQ-022 On ABOVE->BELOW an event {rise_ts, isi, peak} SHALL be pushed; the falling sample is excluded from peak.
REQ-023 isi SHALL be rise_ts minus the previous rise_ts, modulo 2^TS_W; isi SHALL be 0 for the first spike after reset.
REQ-024 The previous rise_ts and spike_count SHALL update on every completed spike, including dropped ones.
REQ-025 FIFO SHALL be first-word-fall-through; evt_valid SHALL rise in the cycle after the edge on which the push occurred into an empty FIFO (1-cycle latency).
REQ-026 A pop SHALL occur on a rising edge with evt_valid and evt_ready both high; evt_* SHALL hold stable while evt_valid is high and evt_ready is low.
REQ-027 When full, a push SHALL succeed if a pop occurs on the same edge; otherwise the event is dropped and overflow SHALL set.
REQ-028 overflow SHALL stay set until reset; spike_count SHALL saturate at 16'hFFFF.

Reset
REQ-029 Reset assertion SHALL immediately force state BELOW, ts=0, FIFO empty, evt_valid=0, spike_count=0, overflow=0, first-spike flag set, and evt_ts, evt_isi and evt_peak to 0.
REQ-030 A spike in progress at reset SHALL be discarded with no event.
REQ-031 Reset deassertion SHALL take effect on the next rising edge of clk.

Structure
REQ-032 Shared package neuron_pkg SHALL hold FRAC_BITS=12, the Q3.12 constants ONE=4096 and HALF=2048, and the event record layout (ts, isi, peak).
REQ-033 Buffering SHALL be a sub-module event_fifo (parameterised width and depth, FWFT, full/empty outputs).
REQ-034 Threshold compare and FSM SHALL be in spike_detector; pure combinational logic SHALL not sit on evt_* outputs.

Verification
REQ-035 th_hi=2048 and th_lo=0 with samples 0,3000,5000,4000,-100 at ts 0..4 -> one event with ts=1, isi=0, peak=5000, and spike_count=1.
REQ-036 Second spike rising at ts=120 after the REQ-035 spike -> event with ts=120 and isi=119.
REQ-037 evt_ready=0 while 9 spikes complete with FIFO_DEPTH=8 -> 8 events retained in order, overflow=1, spike_count=9; draining yields the 8 events in order.
REQ-038 Push to a full FIFO on the same edge as a pop -> no drop and overflow stays 0.
REQ-039 rst asserted while in ABOVE mid-clock -> outputs cleared immediately; after release no event emitted and the next spike has isi=0.
REQ-040 v_valid held low for 50 cycles inside a spike -> ts, FSM and peak unchanged; v_in values on those cycles are ignored.
